// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared state encodings and default sizing for the sweeper
package truth_table_sweeper_pkg;
  localparam int NUM_INPUTS_DEF  = 3;
  localparam int HOLD_CYCLES_DEF = 10;
  typedef enum logic [1:0] {
    SWP_IDLE  = 2'd0,
    SWP_DRIVE = 2'd1,
    SWP_DONE  = 2'd2
  } swp_state_e;
endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// hold_timer: up-counter with clear that flags the last cycle of a hold window
//   clk, reset : clock and synchronous active-high reset
//   clr        : force count to 0 (wins over en)
//   en         : count; wraps to 0 after reaching HOLD_CYCLES-1
//   tc         : count == HOLD_CYCLES-1
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  logic [CW-1:0] count_q, count_d;
  assign tc = count_q == CW'(HOLD_CYCLES - 1);
  always_comb count_d = clr ? '0 : en ? (tc ? '0 : count_q + 1'b1) : count_q;
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector in turn and records f into a truth table
//   clk, reset  : clock and synchronous active-high reset
//   start       : begin a sweep (ignored while busy)
//   f_in        : response of the block under test to vec_out
//   vec_out     : vector driven to the block (bit2=v, bit1=i, bit0=h)
//   busy, done  : sweep in progress / sweep finished and result valid
//   table_out   : bit k is f sampled while vec_out == k
//   ones_count  : number of ones in table_out
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       f_in,
  output logic [NUM_INPUTS-1:0]      vec_out,
  output logic                       busy,
  output logic                       done,
  output logic [2**NUM_INPUTS-1:0]   table_out,
  output logic [NUM_INPUTS:0]        ones_count
);
  localparam int TW = 2**NUM_INPUTS;
  swp_state_e state_q, state_d;
  logic [NUM_INPUTS-1:0] vec_q, vec_d;
  logic [TW-1:0] tab_q, tab_d;
  logic [NUM_INPUTS:0] ones_q, ones_d;
  logic accept, sample, last, tc;
  assign accept = start && state_q != SWP_DRIVE;
  assign sample = state_q == SWP_DRIVE && tc;
  assign last   = vec_q == {NUM_INPUTS{1'b1}};
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state_q == SWP_DRIVE),
    .tc    (tc)
  );
  // The table is cleared on accept, so OR-ing in the sampled bit is a plain write.
  always_comb begin
    state_d = accept ? SWP_DRIVE : (sample && last) ? SWP_DONE : state_q;
    vec_d   = accept ? '0 : (sample && !last) ? vec_q + 1'b1 : vec_q;
    tab_d   = accept ? '0 : sample ? (tab_q | (TW'(f_in) << vec_q)) : tab_q;
    ones_d  = accept ? '0 : ones_q + {{NUM_INPUTS{1'b0}}, sample && f_in};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWP_IDLE;
      vec_q   <= '0;
      tab_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tab_q   <= tab_d;
      ones_q  <= ones_d;
    end
  end
  assign vec_out    = vec_q;
  assign busy       = state_q == SWP_DRIVE;
  assign done       = state_q == SWP_DONE;
  assign table_out  = tab_q;
  assign ones_count = ones_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for two sweeper instances (hold 10 and hold 1)
module tb_truth_table_sweeper;
  logic clk = 0;
  logic reset = 0;
  logic start [2];
  logic f_w [2];
  logic [2:0] vec_w [2];
  logic busy_w [2];
  logic done_w [2];
  logic [7:0] tab_w [2];
  logic [3:0] ones_w [2];
  logic [7:0] fn [2];
  int hold [2] = '{10, 1};
  int checks = 0;
  int failures = 0;
  typedef struct { int id; logic [7:0] t; logic [3:0] n; } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  truth_table_sweeper #(.NUM_INPUTS(3), .HOLD_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start[0]), .f_in(f_w[0]), .vec_out(vec_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .table_out(tab_w[0]), .ones_count(ones_w[0]));
  truth_table_sweeper #(.NUM_INPUTS(3), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .f_in(f_w[1]), .vec_out(vec_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .table_out(tab_w[1]), .ones_count(ones_w[1]));

  // The block under test: a lookup of the current vector in the function chosen for this run.
  assign f_w[0] = fn[0][vec_w[0]];
  assign f_w[1] = fn[1][vec_w[1]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: evaluate the Boolean rule on each vector k = {v,i,h}.
  function automatic logic [7:0] tt(input int mode, input logic [7:0] rnd);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      int v, i, h;
      v = (k >> 2) & 1;
      i = (k >> 1) & 1;
      h = k & 1;
      case (mode)
        0: r[k] = (v & i & h) != 0;
        1: r[k] = (v ^ i ^ h) != 0;
        2: r[k] = h == 0;
        default: r[k] = rnd[k];
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] popc(input logic [7:0] t);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++) s += int'(t[k]);
    return 4'(s);
  endfunction

  task automatic go(input int id, input int mode);
    fn[id] = tt(mode, 8'($urandom));
    sb.push_back('{id, fn[id], popc(fn[id])});
    start[id] = 1;
    @(posedge clk);
    #1 start[id] = 0;
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (!done_w[id] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen%0d", id), 32'(done_w[id]), 1);
    @(negedge clk);
  endtask

  // Monitor: vec_out must step every hold window; on done rising, the result and
  // the number of busy cycles are compared with the oldest expectation for that DUT.
  initial begin
    int bcnt [2];
    logic done_prev [2];
    bcnt = '{0, 0};
    done_prev = '{0, 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (busy_w[i]) begin
          chk($sformatf("vec%0d", i), 32'(vec_w[i]), 32'(bcnt[i] / hold[i]));
          bcnt[i]++;
        end
        if (done_w[i] && !done_prev[i]) begin
          int j;
          j = -1;
          for (int k = 0; k < sb.size(); k++) if (j < 0 && sb[k].id == i) j = k;
          chk($sformatf("sb_entry%0d", i), 32'(j >= 0), 1);
          if (j >= 0) begin
            chk($sformatf("table%0d", i), 32'(tab_w[i]), 32'(sb[j].t));
            chk($sformatf("ones%0d", i), 32'(ones_w[i]), 32'(sb[j].n));
            chk($sformatf("busy_len%0d", i), 32'(bcnt[i]), 32'(8 * hold[i]));
            chk($sformatf("vec_final%0d", i), 32'(vec_w[i]), 7);
            sb.delete(j);
          end
        end
        if (!busy_w[i]) bcnt[i] = 0;
        done_prev[i] = done_w[i];
      end
    end
  end

  task automatic chk_zero(input string name, input int id);
    chk({name, "_busy"}, 32'(busy_w[id]), 0);
    chk({name, "_done"}, 32'(done_w[id]), 0);
    chk({name, "_vec"}, 32'(vec_w[id]), 0);
    chk({name, "_table"}, 32'(tab_w[id]), 0);
    chk({name, "_ones"}, 32'(ones_w[id]), 0);
  endtask

  initial begin
    int n;
    fn = '{8'h00, 8'h00};
    start = '{1, 1};
    reset = 1;
    repeat (2) @(posedge clk);
    #1 chk_zero("rst0", 0);
    chk_zero("rst1", 1);
    reset = 0;
    start = '{0, 0};
    @(posedge clk);
    #1 chk_zero("idle0", 0);
    chk_zero("idle1", 1);

    go(0, 0);
    wait_done(0);
    go(0, 1);
    wait_done(0);
    go(0, 1);
    @(negedge clk);
    chk("restart_table", 32'(tab_w[0]), 0);
    chk("restart_ones", 32'(ones_w[0]), 0);
    chk("restart_busy", 32'(busy_w[0]), 1);
    chk("restart_done", 32'(done_w[0]), 0);
    wait_done(0);

    go(0, 3);
    repeat (24) @(posedge clk);
    #1 start[0] = 1;
    @(posedge clk);
    #1 start[0] = 0;
    wait_done(0);

    go(0, 0);
    n = 0;
    while (vec_w[0] != 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec3", 32'(vec_w[0]), 3);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk_zero("midrst", 0);
    for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].id == 0) sb.delete(k);
    go(0, 2);
    wait_done(0);

    go(1, 2);
    wait_done(1);
    for (int r = 0; r < 3; r++) begin
      go(1, 3);
      wait_done(1);
      go(0, $urandom_range(0, 3));
      wait_done(0);
    end
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
